// File: rtl/butterfly_collect_pkg.sv
// rtl/butterfly_collect_pkg.sv - shared types, constants and slot indexing for the serial collector
package butterfly_collect_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } collect_state_t;

    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 2;

    // Bit offset of one sample inside a packed word: lanes are outer, slots inner.
    function automatic int slot_lsb(input int lane, input int slot, input int pack, input int dw);
        return (lane * pack + slot) * dw;
    endfunction

endpackage

// File: rtl/butterfly_collect_fifo.sv
// rtl/butterfly_collect_fifo.sv - two-entry valid/ready FIFO holding {last, data} packed words
module butterfly_collect_fifo
    import butterfly_collect_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_tvalid,
    input  logic [WIDTH-1:0] push_tdata,
    output logic             pop_tvalid,
    input  logic             pop_tready,
    output logic [WIDTH-1:0] pop_tdata,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             pop;
    logic             push_ok;

    assign pop_tvalid = (count != '0);
    assign pop_tdata  = mem[rd_ptr];
    assign pop        = pop_tvalid && pop_tready;
    // A full FIFO may still take a word when the head leaves in the same cycle.
    assign push_ok    = push_tvalid && ((count < CNT_W'(FIFO_DEPTH)) || pop);

    // Storage, pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_tdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/butterfly_serial_collector.sv
// rtl/butterfly_serial_collector.sv - packs per-lane serial samples into wide frame-delimited words (optional BFLY_COLLECT_PERF_EN counters)
module butterfly_serial_collector
    import butterfly_collect_pkg::*;
#(
    parameter int data_width      = 16,
    parameter int be_parallelism  = 32,
    parameter int OUTPUT_AXI_CHNL = 8,
    parameter int PACK            = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [15:0]                            length,
    input  logic [OUTPUT_AXI_CHNL-1:0]             up_vld,
    input  logic [data_width*be_parallelism-1:0]   up_dat,
    output logic                                   up_rdy,
    output logic                                   dn_vld,
    output logic [data_width*PACK*be_parallelism-1:0] dn_dat,
    output logic                                   dn_last,
    input  logic                                   dn_rdy,
    output logic                                   frame_done,
    output logic                                   err_chnl
`ifdef BFLY_COLLECT_PERF_EN
    ,
    output logic [31:0]                            perf_frames,
    output logic [31:0]                            perf_stall
`endif
);

    localparam int DN_W   = data_width * PACK * be_parallelism;
    localparam int SLOT_W = $clog2(PACK);

    collect_state_t    state;
    logic [15:0]       len_q;
    logic [15:0]       sample_cnt;
    logic [SLOT_W-1:0] slot;
    logic [DN_W-1:0]   pack_reg;
    logic [DN_W-1:0]   word_next;
    logic [CNT_W-1:0]  fifo_count;
    logic [DN_W:0]     fifo_head;
    logic              beat;
    logic              is_last;
    logic              word_done;
    logic              pop;

    assign pop       = dn_vld && dn_rdy;
    assign up_rdy    = (state == COLLECT) && ((fifo_count < CNT_W'(FIFO_DEPTH)) || pop);
    // Only channel 0 qualifies a beat; the other bits only feed the consistency check.
    assign beat      = up_vld[0] && up_rdy;
    assign is_last   = (sample_cnt == (len_q - 16'd1));
    assign word_done = beat && ((slot == SLOT_W'(PACK - 1)) || is_last);

    // Current pack register with this beat's lanes dropped into the active slot.
    always_comb begin
        word_next = pack_reg;
        for (int g = 0; g < be_parallelism; g++) begin
            word_next[slot_lsb(g, int'(slot), PACK, data_width) +: data_width] =
                up_dat[g*data_width +: data_width];
        end
    end

    // Frame FSM: latch length in IDLE, fill slots in COLLECT, clear the pack register per word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_q      <= '0;
            sample_cnt <= '0;
            slot       <= '0;
            pack_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (length != 16'd0) begin
                        state      <= COLLECT;
                        len_q      <= length;
                        sample_cnt <= '0;
                        slot       <= '0;
                        pack_reg   <= '0;
                    end
                end
                COLLECT: begin
                    if (beat) begin
                        sample_cnt <= sample_cnt + 16'd1;
                        slot       <= slot + SLOT_W'(1);
                        // Clearing here leaves unwritten slots of a short final word at zero.
                        pack_reg   <= word_done ? '0 : word_next;
                        if (is_last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky flag for channel valids that disagree while any is asserted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_chnl <= 1'b0;
        end else if ((up_vld != '0) && (up_vld != '1)) begin
            err_chnl <= 1'b1;
        end
    end

    // One-cycle pulse after the frame's last word leaves the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= pop && fifo_head[DN_W];
        end
    end

    butterfly_collect_fifo #(
        .WIDTH (DN_W + 1)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_tvalid (word_done),
        .push_tdata  ({is_last, word_next}),
        .pop_tvalid  (dn_vld),
        .pop_tready  (dn_rdy),
        .pop_tdata   (fifo_head),
        .count       (fifo_count)
    );

    assign dn_dat  = fifo_head[DN_W-1:0];
    assign dn_last = fifo_head[DN_W];

`ifdef BFLY_COLLECT_PERF_EN
    // Completed-frame counter (wrapping) and output back-pressure counter (saturating).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_frames <= '0;
            perf_stall  <= '0;
        end else begin
            if (pop && fifo_head[DN_W]) begin
                perf_frames <= perf_frames + 32'd1;
            end
            if (dn_vld && !dn_rdy && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_butterfly_serial_collector.sv
// tb/tb_butterfly_serial_collector.sv - self-checking bench for butterfly_serial_collector
module tb_butterfly_serial_collector;

    localparam int DW   = 16;
    localparam int NL   = 32;
    localparam int NCH  = 8;
    localparam int PK   = 8;
    localparam int UP_W = DW * NL;
    localparam int DN_W = DW * PK * NL;

    logic              clk;
    logic              rst_n;
    logic [15:0]       length;
    logic [NCH-1:0]    up_vld;
    logic [UP_W-1:0]   up_dat;
    logic              up_rdy;
    logic              dn_vld;
    logic [DN_W-1:0]   dn_dat;
    logic              dn_last;
    logic              dn_rdy;
    logic              frame_done;
    logic              err_chnl;
`ifdef BFLY_COLLECT_PERF_EN
    logic [31:0]       perf_frames;
    logic [31:0]       perf_stall;
`endif

    butterfly_serial_collector #(
        .data_width      (DW),
        .be_parallelism  (NL),
        .OUTPUT_AXI_CHNL (NCH),
        .PACK            (PK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .length     (length),
        .up_vld     (up_vld),
        .up_dat     (up_dat),
        .up_rdy     (up_rdy),
        .dn_vld     (dn_vld),
        .dn_dat     (dn_dat),
        .dn_last    (dn_last),
        .dn_rdy     (dn_rdy),
        .frame_done (frame_done),
        .err_chnl   (err_chnl)
`ifdef BFLY_COLLECT_PERF_EN
        ,
        .perf_frames (perf_frames),
        .perf_stall  (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DN_W-1:0] exp_dat_q [$];
    bit              exp_last_q [$];
    logic [DN_W-1:0] cap [32];
    int              pop_idx = 0;
    int              fd_count = 0;
    bit              pend_fd = 0;
    bit              held_v = 0;
    logic [DN_W-1:0] held_d;

    function automatic logic [15:0] ls(input logic [DN_W-1:0] v, input int g, input int s);
        return v[(g*PK + s)*DW +: DW];
    endfunction

    // Reference word w of a frame: sample i of lane g carries g*256+i, zero past the frame end.
    function automatic logic [DN_W-1:0] model_word(input int len, input int w);
        logic [DN_W-1:0] v;
        v = '0;
        for (int s = 0; s < PK; s++) begin
            if (w*PK + s < len) begin
                for (int g = 0; g < NL; g++) begin
                    v[(g*PK + s)*DW +: DW] = 16'(g*256 + w*PK + s);
                end
            end
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic cmp_word(input string name, input logic [DN_W-1:0] got, input logic [DN_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            for (int g = 0; g < NL; g++) begin
                for (int s = 0; s < PK; s++) begin
                    if (ls(got, g, s) !== ls(exp, g, s)) begin
                        $display("FAIL %s lane=%0d slot=%0d got=%0h exp=%0h", name, g, s, ls(got, g, s), ls(exp, g, s));
                        return;
                    end
                end
            end
        end
    endtask

    // Output checker: every cycle compares the port against the model queue and the stall/pulse rules.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_dat_q.delete();
                exp_last_q.delete();
                pend_fd = 0;
                held_v  = 0;
            end else begin
                chk("frame_done", {31'd0, frame_done}, {31'd0, pend_fd});
                if (frame_done) fd_count++;
                pend_fd = 0;
                if (held_v) cmp_word("stall_stable", dn_dat, held_d);
                if (dn_vld) begin
                    if (exp_dat_q.size() == 0) begin
                        chk("unexpected_word", 32'd1, 32'd0);
                    end else begin
                        cmp_word("dn_dat", dn_dat, exp_dat_q[0]);
                        chk("dn_last", {31'd0, dn_last}, {31'd0, exp_last_q[0]});
                        if (dn_rdy) begin
                            if (pop_idx < 32) cap[pop_idx] = dn_dat;
                            pop_idx++;
                            pend_fd = exp_last_q[0];
                            void'(exp_dat_q.pop_front());
                            void'(exp_last_q.pop_front());
                        end
                    end
                end
                held_v = dn_vld && !dn_rdy;
                held_d = dn_dat;
            end
        end
    end

    // Start a frame, queue its expected words, then feed beats; optional bad-valid beat and reset point.
    task automatic drive_frame(input int len, input int err_beat, input int rst_at);
        int i;
        int budget;
        int nw;
        bit acc;
        length = 16'(len);
        @(posedge clk); #1;
        length = 16'd0;
        nw = (len + PK - 1) / PK;
        for (int w = 0; w < nw; w++) begin
            exp_dat_q.push_back(model_word(len, w));
            exp_last_q.push_back(w == nw - 1);
        end
        i = 0;
        budget = 0;
        while (i < len && budget < 3000) begin
            if (i == rst_at) begin
                up_vld = '0;
                rst_n  = 1'b0;
                @(posedge clk); #1;
                rst_n  = 1'b1;
                @(negedge clk);
                chk("post_rst_dn_vld", {31'd0, dn_vld}, 32'd0);
                chk("post_rst_up_rdy", {31'd0, up_rdy}, 32'd0);
                chk("post_rst_err", {31'd0, err_chnl}, 32'd0);
                @(posedge clk); #1;
                return;
            end
            up_vld = (i == err_beat) ? 8'h0F : 8'hFF;
            for (int g = 0; g < NL; g++) up_dat[g*DW +: DW] = 16'(g*256 + i);
            @(negedge clk);
            acc = up_rdy;
            @(posedge clk); #1;
            if (acc) i++;
            budget++;
        end
        up_vld = '0;
        chk("frame_beats_done", 32'(i), 32'(len));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_dat_q.size() != 0 || pend_fd) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_empty", 32'(exp_dat_q.size()), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        length = 16'd0;
        up_vld = '0;
        up_dat = '0;
        dn_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_dn_vld", {31'd0, dn_vld}, 32'd0);
        chk("rst_dn_last", {31'd0, dn_last}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_err", {31'd0, err_chnl}, 32'd0);
        chk("rst_up_rdy", {31'd0, up_rdy}, 32'd0);
        chk("rst_dn_dat", {31'd0, |dn_dat}, 32'd0);
        @(posedge clk); #1;

        // Full 256-sample frame, no back-pressure.
        pop_idx = 0; fd_count = 0;
        drive_frame(256, -1, -1);
        drain();
        chk("t1_words", 32'(pop_idx), 32'd32);
        chk("t1_frame_done", 32'(fd_count), 32'd1);
        chk("t1_w0_l0_s0", {16'd0, ls(cap[0], 0, 0)}, 32'h0000);
        chk("t1_w3_l2_s5", {16'd0, ls(cap[3], 2, 5)}, 32'd541);
        chk("t1_w31_l31_s7", {16'd0, ls(cap[31], 31, 7)}, 32'h1FFF);

        // Consumer stall of 40 cycles mid-frame.
        pop_idx = 0; fd_count = 0;
        fork
            drive_frame(256, -1, -1);
            begin
                repeat (40) @(posedge clk);
                #1 dn_rdy = 1'b0;
                repeat (30) @(negedge clk);
                chk("stall_up_rdy", {31'd0, up_rdy}, 32'd0);
                chk("stall_dn_vld", {31'd0, dn_vld}, 32'd1);
                repeat (10) @(posedge clk);
                #1 dn_rdy = 1'b1;
            end
        join
        drain();
        chk("t2_words", 32'(pop_idx), 32'd32);
        chk("t2_frame_done", 32'(fd_count), 32'd1);

        // Short frame with a partial last word and one inconsistent-valid beat.
        chk("t3_err_before", {31'd0, err_chnl}, 32'd0);
        pop_idx = 0; fd_count = 0;
        drive_frame(20, 5, -1);
        drain();
        chk("t3_err_after", {31'd0, err_chnl}, 32'd1);
        chk("t3_words", 32'(pop_idx), 32'd3);
        chk("t3_w2_l5_s3", {16'd0, ls(cap[2], 5, 3)}, 32'd1299);
        chk("t3_w2_l5_s4", {16'd0, ls(cap[2], 5, 4)}, 32'd0);
        chk("t3_w1_l0_s0", {16'd0, ls(cap[1], 0, 0)}, 32'd8);

        // Reset at sample 100, then a clean full frame.
        chk("t4_err_sticky", {31'd0, err_chnl}, 32'd1);
        drive_frame(256, -1, 100);
        pop_idx = 0; fd_count = 0;
        drive_frame(256, -1, -1);
        drain();
        chk("t4_words", 32'(pop_idx), 32'd32);
        chk("t4_w0_l1_s1", {16'd0, ls(cap[0], 1, 1)}, 32'd257);
        chk("t4_frame_done", 32'(fd_count), 32'd1);

        // length==0 holds IDLE, then a 4-sample frame.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("len0_up_rdy", {31'd0, up_rdy}, 32'd0);
            chk("len0_dn_vld", {31'd0, dn_vld}, 32'd0);
        end
        @(posedge clk); #1;
        pop_idx = 0; fd_count = 0;
        drive_frame(4, -1, -1);
        drain();
        chk("t5_words", 32'(pop_idx), 32'd1);
        chk("t5_l2_s3", {16'd0, ls(cap[0], 2, 3)}, 32'd515);
        chk("t5_l2_s4", {16'd0, ls(cap[0], 2, 4)}, 32'd0);
        chk("t5_frame_done", 32'(fd_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/butterfly_serial_collector.md
Name: butterfly_serial_collector

Overview:
- Downstream of butterfly_processor Port A serial output.
- Accepts one 16-bit sample per BE lane per beat (be_parallelism lanes in parallel) and packs PACK consecutive samples per lane into one wide word.
- Marks frame boundaries using the programmed FFT/butterfly length and presents packed words on a valid/ready port to the AXI write path.

Parameters:
- data_width, 16, sample width in bits
- be_parallelism, 32, number of BE lanes
- OUTPUT_AXI_CHNL, 8, width of the per-channel valid vector from the processor
- PACK, 8, samples per lane per output word (power of 2, >=2)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- length  in  16  samples per frame, sampled at frame start
- up_vld  in  OUTPUT_AXI_CHNL  per-channel valid from dn_serial_vld_A
- up_dat  in  data_width*be_parallelism  lane g at bits [16g+15:16g]
- up_rdy  out  1  ready to dn_serial_rdy_A
- dn_vld  out  1  packed word valid
- dn_dat  out  data_width*PACK*be_parallelism  lane g slot s at bits [(g*PACK+s)*16 +: 16]; slot 0 = oldest sample
- dn_last  out  1  word holds the final sample of a frame
- dn_rdy  in  1  consumer ready
- frame_done  out  1  one-cycle pulse when the dn_last word is accepted
- err_chnl  out  1  sticky flag: up_vld bits disagreed while any bit was high

Behaviour:
- Reset (rst_n=0 at a clk edge): dn_vld=0, dn_last=0, frame_done=0, err_chnl=0, up_rdy=0. dn_dat=0. Packing state, counters and FIFO cleared. Reset mid-frame discards all partial data.
- Beat accept: up_vld[0] && up_rdy. up_vld != 0 and != all-ones -> err_chnl set (sticky until reset); the beat is still judged on bit 0 only.
- States: IDLE, COLLECT.
  - IDLE: up_rdy=0. Moves to COLLECT on the next cycle when length != 0, latching len_q=length and clearing sample_cnt and slot.
  - length==0 keeps the block in IDLE.
- COLLECT:
  - Each accepted beat writes up_dat lanes into slot position slot of the pack register.
  - slot increments, wrapping at PACK-1; sample_cnt increments.
  - Word complete when slot==PACK-1 or sample_cnt==len_q-1. The word then enters a 2-entry output FIFO with last=(sample_cnt==len_q-1).
  - Unwritten slots of a partial final word are zero.
  - After the last sample: return to IDLE; len_q is re-latched for the next frame.
- up_rdy in COLLECT = FIFO count<2, or count==2 with a dn pop in the same cycle. Registered count; push and pop in the same cycle leave the count unchanged.
- Latency: the completing beat is accepted at edge N; dn_vld=1 after edge N (visible in cycle N+1) when the FIFO was empty.
- Output: dn_vld = FIFO non-empty; dn_dat/dn_last = FIFO head. Pop on dn_vld&&dn_rdy. dn_dat is stable while dn_vld && !dn_rdy.
- frame_done is asserted the cycle after a pop with head last=1.
- length changes mid-frame are ignored until the next IDLE.

Optional Feature:
- Macro BFLY_COLLECT_PERF_EN.
- Defined: adds outputs perf_frames (32, frames completed, wraps) and perf_stall (32, cycles with dn_vld && !dn_rdy, saturating at all-ones). Both cleared by reset.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package butterfly_collect_pkg: state enum (IDLE, COLLECT), FIFO_DEPTH=2 constant, the lane/slot index helper function.
- One sub-module butterfly_collect_fifo: 2-entry valid/ready FIFO carrying {last, data}, parameterised on width.

Test Plan:
- length=256, PACK=8, lane g input = g*256+i for sample i, dn_rdy=1 -> 32 words; word w lane g slot s = g*256+8w+s; dn_last only on word 31; frame_done pulses once.
- length=20, PACK=8 -> 3 words. Word 2 slots 0-3 = samples 16-19, slots 4-7 = 0, dn_last=1.
- dn_rdy held 0 for 40 cycles mid-frame -> FIFO fills to 2, up_rdy drops the cycle after; no sample lost or duplicated after release; dn_dat stable during stall.
- up_vld=8'h0F for one beat -> err_chnl=1 and stays 1. The beat is accepted (bit 0 high), so data continuity holds.
- rst_n=0 for one edge at sample 100 of 256 -> dn_vld=0 next cycle. The following full frame is output correctly, starting at slot 0.
- length=0 -> up_rdy stays 0 and no output. Then length=4 -> one word, dn_last=1, slots 4-7 zero.
